// File: rtl/btn_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : btn_tx_scheduler
// Purpose  : Round-robin scheduler that shares one UART TX FIFO write port
//            among NUM_BTN debounced buttons. Each granted press is written
//            to the FIFO as the message "B<digit>", optionally followed by CR LF.
// Revision : 1.0 - initial release
//
// Optional feature macro:
//   BTN_TX_CRLF_EN - when defined, each message is followed by 8'h0D 8'h0A
//                    (4 bytes in total). When undefined, messages are 2 bytes.
//
// Parameters:
//   NUM_BTN   - number of button requesters (2..10)
//   CHAR_BASE - ASCII code sent for button index 0 (index n -> CHAR_BASE+n)
//   IDX_W     - width of the button index, equal to clog2(NUM_BTN)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   i_btn_pulse  in   one-cycle press pulses, one bit per button
//   i_fifo_full  in   TX FIFO full flag
//   o_fifo_push  out  FIFO write strobe (sampled by the FIFO on rising clk)
//   o_fifo_wdata out  byte to write; 8'h00 whenever o_fifo_push=0
//   o_busy       out  high while a message is in progress
//   o_grant_idx  out  index of the button currently being serviced
//   i_ovf_clr    in   synchronous clear for o_overflow
//   o_overflow   out  sticky: a press arrived while its pending bit was set
// ============================================================================
module btn_tx_scheduler #(
  parameter int         NUM_BTN   = 4,
  parameter logic [7:0] CHAR_BASE = 8'h30,
  parameter int         IDX_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn_pulse,
  input  logic               i_fifo_full,
  output logic               o_fifo_push,
  output logic [7:0]         o_fifo_wdata,
  output logic               o_busy,
  output logic [IDX_W-1:0]   o_grant_idx,
  input  logic               i_ovf_clr,
  output logic               o_overflow
);

`ifdef BTN_TX_CRLF_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_B  = 3'd1,
    ST_SEND_ID = 3'd2,
    ST_SEND_CR = 3'd3,
    ST_SEND_LF = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_B  = 2'd1,
    ST_SEND_ID = 2'd2
  } state_t;
`endif

  state_t             r_state;
  logic [NUM_BTN-1:0] r_pending;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_overflow;

  logic               w_grant_valid;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [NUM_BTN-1:0] w_clr_mask;
  logic               w_ovf_set;
  logic               w_push;
  logic [7:0]         w_wdata;

  // (base + off) mod NUM_BTN; off never exceeds NUM_BTN, so one
  // conditional subtraction is enough and the sum fits in IDX_W+1 bits.
  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                               input int unsigned      off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(NUM_BTN)) begin
      sum = sum - (IDX_W+1)'(NUM_BTN);
    end
    return sum[IDX_W-1:0];
  endfunction

  // Round-robin search starting just after the last grant. Iterating from the
  // farthest candidate down to the nearest lets the nearest set bit win.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int i = NUM_BTN; i >= 1; i--) begin
      if (r_pending[f_wrap(r_last_grant, i)]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = f_wrap(r_last_grant, i);
      end
    end
  end

  // A pending bit is only consumed when the IDLE state actually issues a grant.
  always_comb begin
    w_clr_mask = '0;
    if (r_state == ST_IDLE && w_grant_valid) begin
      w_clr_mask = NUM_BTN'(1) << w_grant_idx;
    end
  end

  // A press on a bit that is being granted this cycle is a fresh request,
  // not an overflow.
  assign w_ovf_set = |(i_btn_pulse & r_pending & ~w_clr_mask);

  assign w_push = (r_state != ST_IDLE) && !i_fifo_full;

  always_comb begin
    w_wdata = 8'h00;
    if (w_push) begin
      case (r_state)
        ST_SEND_B:  w_wdata = 8'h42;
        ST_SEND_ID: w_wdata = CHAR_BASE + 8'(r_grant_idx);
`ifdef BTN_TX_CRLF_EN
        ST_SEND_CR: w_wdata = 8'h0D;
        ST_SEND_LF: w_wdata = 8'h0A;
`endif
        default:    w_wdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_last_grant <= IDX_W'(NUM_BTN - 1);
      r_grant_idx  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      // Set has priority over the grant clear so a coincident press is kept.
      r_pending <= (r_pending & ~w_clr_mask) | i_btn_pulse;

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_grant_idx  <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_state      <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (w_push) r_state <= ST_SEND_ID;
        end
        ST_SEND_ID: begin
`ifdef BTN_TX_CRLF_EN
          if (w_push) r_state <= ST_SEND_CR;
`else
          if (w_push) r_state <= ST_IDLE;
`endif
        end
`ifdef BTN_TX_CRLF_EN
        ST_SEND_CR: begin
          if (w_push) r_state <= ST_SEND_LF;
        end
        ST_SEND_LF: begin
          if (w_push) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_fifo_push  = w_push;
  assign o_fifo_wdata = w_wdata;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_grant_idx  = r_grant_idx;
  assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/btn_tx_scheduler.md
Name: btn_tx_scheduler

Overview:
- Collects single-cycle debounced button pulses from NUM_BTN requesters and shares one TX FIFO write port between them using round-robin arbitration.
- For each granted press, writes a short ASCII message into the UART TX FIFO: 'B', then the button digit, then optionally CR LF.
- Sits between the per-button debounce instances and the TX FIFO push interface.

Parameters:
- NUM_BTN, 4, number of button requesters; legal range 2..10.
- CHAR_BASE, 8'h30, ASCII code sent for button index 0; index n sends CHAR_BASE+n.
- IDX_W, 2, width of button index; must equal clog2(NUM_BTN).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- i_btn_pulse  input  NUM_BTN  debounced one-cycle press pulses, one bit per button.
- i_fifo_full  input  1  TX FIFO full flag.
- o_fifo_push  output  1  FIFO write strobe; the FIFO samples it on the rising clk edge.
- o_fifo_wdata  output  8  byte to write; valid whenever o_fifo_push=1.
- o_busy  output  1  high while a message is being sent (any state other than IDLE).
- o_grant_idx  output  IDX_W  index of the button currently being serviced.
- i_ovf_clr  input  1  synchronous clear for o_overflow.
- o_overflow  output  1  sticky flag: a press arrived while that button's pending bit was already set.

Behaviour:
- Reset state: state=IDLE, pending=0, last_grant=NUM_BTN-1, o_grant_idx=0, o_overflow=0. Outputs o_fifo_push=0 and o_busy=0.
- Pending register:
  - pending[n] is set on the cycle after i_btn_pulse[n]=1.
  - It is cleared in the cycle the arbiter grants button n.
  - If a set and a clear hit the same bit in the same cycle, the set wins, so the new press stays pending.
- Overflow:
  - i_btn_pulse[n]=1 while pending[n]=1 and that bit is not being cleared this cycle sets o_overflow. The press is dropped.
  - i_ovf_clr=1 clears o_overflow. If set and clear coincide, the set wins.
- State machine states: IDLE, SEND_B, SEND_ID, SEND_CR, SEND_LF (the last two only exist with the optional feature).
- IDLE:
  - If pending is non-zero, grant the first set bit searching from last_grant+1 upward with wrap-around.
  - On grant: register o_grant_idx, set last_grant to the granted index, clear its pending bit, and go to SEND_B.
  - The grant decision is registered; nothing is pushed in IDLE.
- SEND_x states:
  - o_fifo_push = !i_fifo_full (combinational).
  - o_fifo_wdata is 8'h42 in SEND_B and CHAR_BASE+o_grant_idx in SEND_ID.
  - The state advances only on a cycle where push=1. While full, the machine holds and the data stays stable.
  - After the last byte the machine returns to IDLE, and needs at least one IDLE cycle before the next grant.
- o_fifo_wdata is 8'h00 whenever push=0.
- Latency: a pulse at cycle t sets pending at t+1 and is granted at t+1. The first push occurs at t+2 if the machine was IDLE and the FIFO was not full.
- Message throughput: 2 (or 4) push cycles plus 1 IDLE cycle per message, with no stalls.
- Reset mid-message: the current message is abandoned, no further bytes are pushed, and all pending presses are lost.
- A press of the button currently being sent is simply queued as pending; it is not an overflow.

Optional Feature:
- Macro BTN_TX_CRLF_EN.
- When defined: the sequence after SEND_ID continues through SEND_CR (8'h0D) and SEND_LF (8'h0A), giving a 4-byte message.
- When undefined: SEND_ID returns directly to IDLE, giving a 2-byte message, and the SEND_CR/SEND_LF states are not synthesized.

Test Plan:
- Single press: i_btn_pulse=4'b0100 for one cycle, FIFO never full -> pushes 8'h42 then 8'h32 (plus 8'h0D, 8'h0A with BTN_TX_CRLF_EN) on consecutive cycles. First push is 2 cycles after the pulse; o_grant_idx=2.
- Simultaneous presses: i_btn_pulse=4'b1011 in one cycle after reset -> digits are sent in order '0','1','3'. o_overflow stays 0.
- Round-robin fairness: after button 1 is served, pulse 4'b0011 -> button 0 is not favored unless it comes next in rotation; the expected order is '0','1' only because last_grant=1 wraps to 0.
- FIFO stall: hold i_fifo_full=1 for 5 cycles starting in SEND_ID -> o_fifo_push=0 throughout and the state is held. The digit byte is pushed on the first cycle after full drops.
- Overflow: pulse button 3 twice while pending[3]=1 (arbiter busy with button 0) -> o_overflow=1 and only one message for '3' is sent. i_ovf_clr=1 then returns o_overflow to 0.
- Reset mid-message: assert rst during SEND_ID with pending=4'b0110 -> push drops immediately and pending=0. After release, no bytes are pushed until a new pulse arrives.
